// File: rtl/trng_fifo_wb.sv
// Wishbone-readable FIFO that captures one 32-bit TRNG word per rising edge of trng_valid_i.
// Provides data/status/control/threshold registers and a level interrupt.
module trng_fifo_wb #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_WD = 4
) (
  input  logic        wb_clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [8:0]  wb_adr_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        trng_valid_i,
  input  logic [31:0] trng_data_i,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_WD-1:0] CountFull = CNT_WD'(DEPTH);

  typedef enum logic [1:0] {
    RegData   = 2'd0,
    RegStatus = 2'd1,
    RegCtrl   = 2'd2,
    RegThresh = 2'd3
  } reg_e;

  logic [31:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WD-1:0] count_q, count_d;
  logic [CNT_WD-1:0] thresh_q, thresh_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              valid_q;
  logic              ack_q;
  logic [31:0]       dat_q, dat_d;
  logic              irq_q, irq_d;

  logic        acc, acc_rd, acc_wr;
  reg_e        sel;
  logic        empty, full;
  logic        pop_req, pop;
  logic        push_req, push;
  logic        flush;
  logic [31:0] rdata;

  // Address bits above the register select, byte enables and most data bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[8:2], wb_sel_i, wb_dat_i};

  assign sel    = reg_e'(wb_adr_i[1:0]);
  assign acc    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign acc_rd = acc & ~wb_we_i;
  assign acc_wr = acc & wb_we_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountFull);

  assign pop_req  = acc_rd & (sel == RegData);
  assign pop      = pop_req & ~empty;
  assign flush    = acc_wr & (sel == RegCtrl) & wb_dat_i[2];
  assign push_req = trng_valid_i & ~valid_q & enable_q & ~flush;
  // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_WD'(1);
        2'b01:   count_d = count_q - CNT_WD'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    if (acc_wr && sel == RegStatus) begin
      if (wb_dat_i[18]) ovf_d = 1'b0;
      if (wb_dat_i[19]) unf_d = 1'b0;
    end
    if (acc_wr && sel == RegCtrl) begin
      enable_d = wb_dat_i[0];
      irq_en_d = wb_dat_i[1];
    end
    if (acc_wr && sel == RegThresh) thresh_d = wb_dat_i[CNT_WD-1:0];
    // A new event wins over a same-cycle W1C clear.
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (pop_req && empty)         unf_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      RegData: begin
        if (!empty) rdata = mem_q[rd_ptr_q];
      end
      RegStatus: begin
        rdata[CNT_WD-1:0] = count_q;
        rdata[16]         = empty;
        rdata[17]         = full;
        rdata[18]         = ovf_q;
        rdata[19]         = unf_q;
      end
      RegCtrl: begin
        rdata[0] = enable_q;
        rdata[1] = irq_en_q;
      end
      RegThresh: begin
        rdata[CNT_WD-1:0] = thresh_q;
      end
      default: rdata = '0;
    endcase
  end

  assign dat_d = acc_rd ? rdata : 32'h0;
  assign irq_d = irq_en_d & (((thresh_d != '0) & (count_d >= thresh_d)) | ovf_d);

  always_ff @(posedge wb_clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      thresh_q <= '0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      thresh_q <= thresh_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= trng_valid_i;
      ack_q    <= acc;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
    end
  end

  // Storage carries no reset; stale words are never visible because count gates reads.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_i && push) mem_q[wr_ptr_q] <= trng_data_i;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_trng_fifo_wb.sv
// Scoreboard bench for trng_fifo_wb: bus tasks queue expected read data,
// a negedge monitor pops and compares on every acknowledge.
module tb_trng_fifo_wb;

  localparam logic [1:0] AData = 2'd0, AStat = 2'd1, ACtrl = 2'd2, AThr = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [8:0]  wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        trng_valid;
  logic [31:0] trng_data;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  bit          q_rd  [$];
  logic [31:0] q_exp [$];
  int          q_id  [$];
  bit          m_rd;
  logic [31:0] m_exp;
  int          m_id;

  always #5 clk = ~clk;

  trng_fifo_wb #(.DEPTH(8), .CNT_WD(4)) dut (
    .wb_clk_i     (clk),
    .rst_i        (rst),
    .wb_cyc_i     (wb_cyc),
    .wb_stb_i     (wb_stb),
    .wb_adr_i     (wb_adr),
    .wb_we_i      (wb_we),
    .wb_dat_i     (wb_dat_w),
    .wb_sel_i     (wb_sel),
    .wb_dat_o     (wb_dat_r),
    .wb_ack_o     (wb_ack),
    .trng_valid_i (trng_valid),
    .trng_data_i  (trng_data),
    .irq_o        (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wb_ack) begin
      if (q_rd.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        m_rd  = q_rd.pop_front();
        m_exp = q_exp.pop_front();
        m_id  = q_id.pop_front();
        if (m_rd) check($sformatf("read_%0d", m_id), wb_dat_r, m_exp);
      end
    end else begin
      check("dat_zero_without_ack", wb_dat_r, 32'h0);
    end
  end

  task automatic bus(input bit we, input logic [1:0] adr, input logic [31:0] wdat,
                     input logic [31:0] exp);
    @(posedge clk);
    #1;
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_adr   = {7'($urandom), adr};
    wb_sel   = 4'($urandom);
    wb_dat_w = wdat;
    q_rd.push_back(!we);
    q_exp.push_back(exp);
    q_id.push_back(n_acc);
    n_acc++;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] adr, input logic [31:0] exp);
    bus(1'b0, adr, 32'h0, exp);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [31:0] d);
    bus(1'b1, adr, d, 32'h0);
  endtask

  task automatic trng_push(input logic [31:0] d);
    @(posedge clk);
    #1;
    trng_data  = d;
    trng_valid = 1'b1;
    @(posedge clk);
    #1;
    trng_valid = 1'b0;
  endtask

  task automatic push_and_read(input logic [31:0] d, input logic [31:0] exp);
    @(posedge clk);
    #1;
    trng_data  = d;
    trng_valid = 1'b1;
    wb_cyc     = 1'b1;
    wb_stb     = 1'b1;
    wb_we      = 1'b0;
    wb_adr     = {7'h0, AData};
    q_rd.push_back(1'b1);
    q_exp.push_back(exp);
    q_id.push_back(n_acc);
    n_acc++;
    @(posedge clk);
    #1;
    trng_valid = 1'b0;
    wb_cyc     = 1'b0;
    wb_stb     = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    wb_cyc     = 1'b0;
    wb_stb     = 1'b0;
    wb_we      = 1'b0;
    wb_adr     = '0;
    wb_dat_w   = '0;
    wb_sel     = '0;
    trng_valid = 1'b0;
    trng_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(wb_ack), 32'd0);
    check("reset_dat", wb_dat_r, 32'h0);
    check("reset_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    rd(AStat, 32'h0001_0000);
    rd(ACtrl, 32'h0);
    rd(AThr,  32'h0);

    // Basic push/pop, data-register write ignored, underflow sticky and W1C
    wr(ACtrl, 32'h1);
    wr(AData, 32'hDEAD_BEEF);
    rd(AStat, 32'h0001_0000);
    trng_push(32'hA1);
    trng_push(32'hB2);
    trng_push(32'hC3);
    rd(AStat, 32'h0000_0003);
    rd(AData, 32'hA1);
    rd(AData, 32'hB2);
    rd(AData, 32'hC3);
    rd(AData, 32'h0);
    rd(AStat, 32'h0009_0000);
    wr(AStat, 32'h0008_0000);
    rd(AStat, 32'h0001_0000);

    // Overflow: nine pushes into depth 8
    for (int i = 0; i < 9; i++) trng_push(32'h100 + 32'(i));
    rd(AStat, 32'h0006_0008);
    for (int i = 0; i < 8; i++) rd(AData, 32'h100 + 32'(i));
    rd(AStat, 32'h0005_0000);
    wr(AStat, 32'h0004_0000);
    rd(AStat, 32'h0001_0000);

    // Threshold interrupt
    wr(AThr, 32'h4);
    wr(ACtrl, 32'h3);
    rd(AThr, 32'h4);
    for (int i = 0; i < 3; i++) trng_push(32'h200 + 32'(i));
    check("irq_below_thresh", 32'(irq), 32'd0);
    trng_push(32'h203);
    check("irq_at_thresh", 32'(irq), 32'd1);
    rd(AData, 32'h200);
    check("irq_after_pop", 32'(irq), 32'd0);
    for (int i = 1; i < 4; i++) rd(AData, 32'h200 + 32'(i));
    wr(ACtrl, 32'h1);

    // Full FIFO with coincident push and pop
    for (int i = 0; i < 8; i++) trng_push(32'h300 + 32'(i));
    push_and_read(32'h308, 32'h300);
    rd(AStat, 32'h0002_0008);
    for (int i = 1; i < 9; i++) rd(AData, 32'h300 + 32'(i));
    rd(AStat, 32'h0001_0000);

    // Flush, then pointer wrap
    for (int i = 0; i < 5; i++) trng_push(32'h500 + 32'(i));
    wr(ACtrl, 32'h5);
    rd(AStat, 32'h0001_0000);
    rd(ACtrl, 32'h1);
    for (int i = 0; i < 12; i++) begin
      trng_push(32'h400 + 32'(i));
      rd(AData, 32'h400 + 32'(i));
    end
    rd(AStat, 32'h0001_0000);

    // Edge seen while disabled is never stored
    wr(ACtrl, 32'h0);
    trng_push(32'h55);
    wr(ACtrl, 32'h1);
    repeat (2) @(posedge clk);
    rd(AStat, 32'h0001_0000);

    // Reset alongside a pending data read, valid held high across release
    trng_push(32'h77);
    @(posedge clk);
    #1;
    wb_cyc     = 1'b1;
    wb_stb     = 1'b1;
    wb_we      = 1'b0;
    wb_adr     = {7'h0, AData};
    rst        = 1'b1;
    trng_valid = 1'b1;
    trng_data  = 32'h99;
    @(posedge clk);
    #1;
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", 32'(wb_ack), 32'd0);
    check("rst_mid_dat", wb_dat_r, 32'h0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd(AStat, 32'h0001_0000);
    trng_valid = 1'b0;
    wr(ACtrl, 32'h1);
    repeat (2) @(posedge clk);
    rd(AStat, 32'h0001_0000);
    rd(ACtrl, 32'h1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
